// File: rtl/axi_master_arbiter_pkg.sv
// axi_master_arbiter_pkg: shared types for the arbiter (FSM states, AXI response codes)
package axi_master_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} axi_response_t;
endpackage

// File: rtl/axi_master_arbiter_if.sv
// axi_master_arbiter_if: client-side request/grant/done bundle plus the axi_master command port.
//   slave  modport: the arbiter (takes client requests, drives axi_master commands)
//   master modport: the environment (clients and axi_master)
interface axi_master_arbiter_if #(parameter int N = 4);
  import axi_master_arbiter_pkg::*;
  logic [N-1:0]        write_request_i;
  logic [N-1:0][31:0]  write_address_i;
  logic [N-1:0][31:0]  write_data_i;
  logic [N-1:0][3:0]   write_strobe_i;
  logic [N-1:0]        write_grant_o;
  logic [N-1:0]        write_done_o;
  axi_response_t       write_response_o;
  logic [N-1:0]        read_request_i;
  logic [N-1:0][31:0]  read_address_i;
  logic [N-1:0]        read_grant_o;
  logic [N-1:0]        read_done_o;
  logic [31:0]         read_data_o;
  axi_response_t       read_response_o;
  logic [31:0]         m_write_address_o;
  logic [31:0]         m_write_data_o;
  logic [3:0]          m_write_strobe_o;
  logic                m_write_start_o;
  logic                m_write_done_i;
  axi_response_t       m_write_response_i;
  logic [31:0]         m_read_address_o;
  logic                m_read_start_o;
  logic                m_read_done_i;
  logic [31:0]         m_read_data_i;
  axi_response_t       m_read_response_i;
  modport slave (
    input  write_request_i, write_address_i, write_data_i, write_strobe_i, read_request_i, read_address_i,
           m_write_done_i, m_write_response_i, m_read_done_i, m_read_data_i, m_read_response_i,
    output write_grant_o, write_done_o, write_response_o, read_grant_o, read_done_o, read_data_o,
           read_response_o, m_write_address_o, m_write_data_o, m_write_strobe_o, m_write_start_o,
           m_read_address_o, m_read_start_o
  );
  modport master (
    output write_request_i, write_address_i, write_data_i, write_strobe_i, read_request_i, read_address_i,
           m_write_done_i, m_write_response_i, m_read_done_i, m_read_data_i, m_read_response_i,
    input  write_grant_o, write_done_o, write_response_o, read_grant_o, read_done_o, read_data_o,
           read_response_o, m_write_address_o, m_write_data_o, m_write_strobe_o, m_write_start_o,
           m_read_address_o, m_read_start_o
  );
endinterface

// File: rtl/axi_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr_i with wrap.
//   req_i: request vector; ptr_i: highest-priority index; gnt_o/idx_o: winner; any_o: any request
module rr_arbiter #(parameter int N = 4) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    idx_o = '0;
    // scan from the farthest offset down so the closest request to ptr wins
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (req_i[j]) idx_o = j;
    end
    any_o = |req_i;
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: shares one axi_master write/read port between NUM_REQUESTERS clients.
//   ACLK/ARESETN: clock, async active-low reset; bus: client requests/grants/dones and axi_master commands.
//   Write and read channels run independent IDLE->ISSUE->WAIT round-robin FSMs with optional timeout.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic ACLK,
  input logic ARESETN,
  axi_master_arbiter_if.slave bus
);
  localparam int N = NUM_REQUESTERS;
  localparam int IW = $clog2(N);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  arb_state_t w_state_q, w_state_d, r_state_q, r_state_d;
  logic [IW-1:0] w_owner_q, w_owner_d, w_ptr_q, w_ptr_d, w_idx, r_owner_q, r_owner_d, r_ptr_q, r_ptr_d, r_idx;
  logic [N-1:0] w_sel_q, w_sel_d, w_done_q, w_done_d, w_gnt, r_sel_q, r_sel_d, r_done_q, r_done_d, r_gnt;
  logic [CW-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [31:0] w_addr_q, w_addr_d, w_data_q, w_data_d, r_addr_q, r_addr_d, r_data_q, r_data_d;
  logic [3:0] w_strb_q, w_strb_d;
  axi_response_t w_resp_q, w_resp_d, r_resp_q, r_resp_d;
  logic w_any, r_any, w_end, r_end;
  rr_arbiter #(.N(N)) u_wr_rr (.req_i(bus.write_request_i), .ptr_i(w_ptr_q), .gnt_o(w_gnt), .idx_o(w_idx), .any_o(w_any));
  rr_arbiter #(.N(N)) u_rd_rr (.req_i(bus.read_request_i), .ptr_i(r_ptr_q), .gnt_o(r_gnt), .idx_o(r_idx), .any_o(r_any));
  // a transaction ends on the master's done or when the wait budget runs out
  assign w_end = bus.m_write_done_i || (TO_EN && w_cnt_q == CNT_LAST);
  assign r_end = bus.m_read_done_i || (TO_EN && r_cnt_q == CNT_LAST);
  always_comb begin
    w_state_d = w_state_q;
    w_owner_d = w_owner_q;
    w_sel_d = w_sel_q;
    w_ptr_d = w_ptr_q;
    w_cnt_d = w_cnt_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_strb_d = w_strb_q;
    w_done_d = '0;
    w_resp_d = w_resp_q;
    case (w_state_q)
      IDLE: if (w_any) begin
        w_state_d = ISSUE;
        w_owner_d = w_idx;
        w_sel_d = w_gnt;
        w_addr_d = bus.write_address_i[w_idx];
        w_data_d = bus.write_data_i[w_idx];
        w_strb_d = bus.write_strobe_i[w_idx];
      end
      ISSUE: begin
        w_state_d = WAIT;
        w_cnt_d = '0;
      end
      default: if (w_end) begin
        w_state_d = IDLE;
        w_done_d = w_sel_q;
        w_ptr_d = w_owner_q == IW'(N - 1) ? '0 : w_owner_q + 1'b1;
        w_resp_d = bus.m_write_done_i ? bus.m_write_response_i : DECERR;
      end else w_cnt_d = w_cnt_q + 1'b1;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    r_owner_d = r_owner_q;
    r_sel_d = r_sel_q;
    r_ptr_d = r_ptr_q;
    r_cnt_d = r_cnt_q;
    r_addr_d = r_addr_q;
    r_data_d = r_data_q;
    r_done_d = '0;
    r_resp_d = r_resp_q;
    case (r_state_q)
      IDLE: if (r_any) begin
        r_state_d = ISSUE;
        r_owner_d = r_idx;
        r_sel_d = r_gnt;
        r_addr_d = bus.read_address_i[r_idx];
      end
      ISSUE: begin
        r_state_d = WAIT;
        r_cnt_d = '0;
      end
      default: if (r_end) begin
        r_state_d = IDLE;
        r_done_d = r_sel_q;
        r_ptr_d = r_owner_q == IW'(N - 1) ? '0 : r_owner_q + 1'b1;
        r_resp_d = bus.m_read_done_i ? bus.m_read_response_i : DECERR;
        r_data_d = bus.m_read_done_i ? bus.m_read_data_i : '0;
      end else r_cnt_d = r_cnt_q + 1'b1;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      w_state_q <= IDLE;
      w_owner_q <= '0;
      w_sel_q <= '0;
      w_ptr_q <= '0;
      w_cnt_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      w_done_q <= '0;
      w_resp_q <= OKAY;
      r_state_q <= IDLE;
      r_owner_q <= '0;
      r_sel_q <= '0;
      r_ptr_q <= '0;
      r_cnt_q <= '0;
      r_addr_q <= '0;
      r_data_q <= '0;
      r_done_q <= '0;
      r_resp_q <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_owner_q <= w_owner_d;
      w_sel_q <= w_sel_d;
      w_ptr_q <= w_ptr_d;
      w_cnt_q <= w_cnt_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      w_done_q <= w_done_d;
      w_resp_q <= w_resp_d;
      r_state_q <= r_state_d;
      r_owner_q <= r_owner_d;
      r_sel_q <= r_sel_d;
      r_ptr_q <= r_ptr_d;
      r_cnt_q <= r_cnt_d;
      r_addr_q <= r_addr_d;
      r_data_q <= r_data_d;
      r_done_q <= r_done_d;
      r_resp_q <= r_resp_d;
    end
  assign bus.write_grant_o = w_state_q == ISSUE ? w_sel_q : '0;
  assign bus.m_write_start_o = w_state_q == ISSUE;
  assign bus.m_write_address_o = w_addr_q;
  assign bus.m_write_data_o = w_data_q;
  assign bus.m_write_strobe_o = w_strb_q;
  assign bus.write_done_o = w_done_q;
  assign bus.write_response_o = w_resp_q;
  assign bus.read_grant_o = r_state_q == ISSUE ? r_sel_q : '0;
  assign bus.m_read_start_o = r_state_q == ISSUE;
  assign bus.m_read_address_o = r_addr_q;
  assign bus.read_done_o = r_done_q;
  assign bus.read_data_o = r_data_q;
  assign bus.read_response_o = r_resp_q;
endmodule

// File: tb/tb_axi_master_arbiter.sv
// tb_axi_master_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model
module tb_axi_master_arbiter;
  import axi_master_arbiter_pkg::*;
  localparam int N = 4;
  typedef struct {
    bit rd;
    int client;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0] strb;
    axi_response_t resp;
  } vec_t;
  logic ACLK = 0;
  logic ARESETN = 1;
  always #5 ACLK = ~ACLK;
  axi_master_arbiter_if #(.N(N)) bus();
  axi_master_arbiter #(.NUM_REQUESTERS(N), .TIMEOUT_CYCLES(16)) dut (.ACLK(ACLK), .ARESETN(ARESETN), .bus(bus));
  int checks = 0, failures = 0, cyc_n = 0;
  int wr_lat = 0, rd_lat = 0, wr_due = -1, rd_due = -1;
  axi_response_t wr_resp_s = OKAY, rd_resp_s = OKAY;
  logic [31:0] rd_data_s = '0;
  vec_t vecs[8];
  vec_t v;
  logic [N-1:0] oh;
  int gc[2], dc[2], own[2], freec[2], ptr[2];
  axi_response_t tresp[2], lresp[2];
  logic [31:0] tdata, ldata, eaddr[2], edata;
  logic [3:0] estrb;
  int lat, w;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc_n, act, exp);
    end
  endtask
  // advance one clock, then act as axi_master: answer each start after the programmed latency (-1 = never)
  task automatic cyc();
    @(posedge ACLK);
    #1;
    cyc_n++;
    if (bus.m_write_start_o) wr_due = wr_lat < 0 ? -1 : cyc_n + 1 + wr_lat;
    if (bus.m_read_start_o) rd_due = rd_lat < 0 ? -1 : cyc_n + 1 + rd_lat;
    bus.m_write_done_i = cyc_n == wr_due;
    bus.m_write_response_i = wr_resp_s;
    bus.m_read_done_i = cyc_n == rd_due;
    bus.m_read_response_i = rd_resp_s;
    bus.m_read_data_i = rd_data_s;
  endtask
  task automatic clear_inputs();
    bus.write_request_i = '0;
    bus.write_address_i = '0;
    bus.write_data_i = '0;
    bus.write_strobe_i = '0;
    bus.read_request_i = '0;
    bus.read_address_i = '0;
    bus.m_write_done_i = 0;
    bus.m_write_response_i = OKAY;
    bus.m_read_done_i = 0;
    bus.m_read_response_i = OKAY;
    bus.m_read_data_i = '0;
  endtask
  task automatic do_reset();
    ARESETN = 0;
    clear_inputs();
    wr_due = -1;
    rd_due = -1;
    repeat (2) cyc();
    ARESETN = 1;
  endtask
  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    for (int i = 0; i < N; i++) if (req[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  initial begin
    vecs[0] = '{0, 0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 4'hF, OKAY};
    vecs[1] = '{0, 2, 32'h0000_2004, 32'hA5A5_5A5A, 32'h0, 4'h3, SLVERR};
    vecs[2] = '{1, 3, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 4'h0, OKAY};
    vecs[3] = '{1, 1, 32'h0000_3010, 32'h0, 32'h1111_2222, 4'h0, SLVERR};
    vecs[4] = '{1, 0, 32'h0000_3020, 32'h0, 32'h3333_4444, 4'h0, OKAY};
    vecs[5] = '{0, 1, 32'h0000_4000, 32'h0BAD_CAFE, 32'h0, 4'h8, DECERR};
    vecs[6] = '{0, 3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 4'h1, EXOKAY};
    vecs[7] = '{1, 2, 32'h0000_0000, 32'h0, 32'h8000_0001, 4'h0, EXOKAY};
    clear_inputs();
    #2 ARESETN = 0;
    #1;
    check("rst_wgrant", bus.write_grant_o, 0);
    check("rst_rgrant", bus.read_grant_o, 0);
    check("rst_wdone", bus.write_done_o, 0);
    check("rst_rdone", bus.read_done_o, 0);
    check("rst_wresp", bus.write_response_o, OKAY);
    check("rst_rresp", bus.read_response_o, OKAY);
    check("rst_rdata", bus.read_data_o, 0);
    check("rst_starts", {bus.m_write_start_o, bus.m_read_start_o}, 0);
    check("rst_maddr", bus.m_write_address_o | bus.m_read_address_o, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      oh = N'(1 << v.client);
      if (!v.rd) begin
        bus.write_request_i[v.client] = 1;
        bus.write_address_i[v.client] = v.addr;
        bus.write_data_i[v.client] = v.wdata;
        bus.write_strobe_i[v.client] = v.strb;
        wr_lat = 0;
        wr_resp_s = v.resp;
      end else begin
        bus.read_request_i[v.client] = 1;
        bus.read_address_i[v.client] = v.addr;
        rd_lat = 0;
        rd_resp_s = v.resp;
        rd_data_s = v.rdata;
      end
      cyc();
      if (!v.rd) begin
        check("vec_wgrant", bus.write_grant_o, oh);
        check("vec_wstart", bus.m_write_start_o, 1);
        check("vec_waddr", bus.m_write_address_o, v.addr);
        check("vec_wdata", bus.m_write_data_o, v.wdata);
        check("vec_wstrb", bus.m_write_strobe_o, v.strb);
        bus.write_request_i[v.client] = 0;
      end else begin
        check("vec_rgrant", bus.read_grant_o, oh);
        check("vec_rstart", bus.m_read_start_o, 1);
        check("vec_raddr", bus.m_read_address_o, v.addr);
        bus.read_request_i[v.client] = 0;
      end
      cyc();
      check("vec_grant_1cyc", {bus.write_grant_o, bus.read_grant_o, bus.m_write_start_o, bus.m_read_start_o}, 0);
      cyc();
      check("vec_done", v.rd ? bus.read_done_o : bus.write_done_o, oh);
      check("vec_resp", v.rd ? bus.read_response_o : bus.write_response_o, v.resp);
      if (v.rd) check("vec_rdata", bus.read_data_o, v.rdata);
      cyc();
      check("vec_done_1cyc", bus.write_done_o | bus.read_done_o, 0);
      check("vec_resp_hold", v.rd ? bus.read_response_o : bus.write_response_o, v.resp);
    end
    do_reset();
    for (int k = 0; k < N; k++) begin
      bus.write_request_i[k] = 1;
      bus.write_address_i[k] = 32'(k * 256);
    end
    wr_lat = 0;
    wr_resp_s = OKAY;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("rr_grant", bus.write_grant_o, 1 << (k % N));
      check("rr_addr", bus.m_write_address_o, (k % N) * 256);
      cyc();
      cyc();
      check("rr_done", bus.write_done_o, 1 << (k % N));
    end
    do_reset();
    bus.write_request_i[1] = 1;
    bus.write_address_i[1] = 32'h5000;
    bus.write_data_i[1] = 32'h77;
    bus.write_strobe_i[1] = 4'hF;
    bus.read_request_i[2] = 1;
    bus.read_address_i[2] = 32'h6000;
    wr_lat = 0;
    rd_lat = 1;
    rd_data_s = 32'h1234_5678;
    rd_resp_s = OKAY;
    cyc();
    check("cc_wgrant", bus.write_grant_o, 4'b0010);
    check("cc_rgrant", bus.read_grant_o, 4'b0100);
    check("cc_raddr", bus.m_read_address_o, 32'h6000);
    bus.write_request_i = '0;
    bus.read_request_i = '0;
    cyc();
    cyc();
    check("cc_wdone", bus.write_done_o, 4'b0010);
    check("cc_rdone_early", bus.read_done_o, 0);
    cyc();
    check("cc_rdone", bus.read_done_o, 4'b0100);
    check("cc_rdata", bus.read_data_o, 32'h1234_5678);
    check("cc_wdone_1cyc", bus.write_done_o, 0);
    do_reset();
    bus.write_request_i[2] = 1;
    wr_lat = -1;
    cyc();
    check("to_grant", bus.write_grant_o, 4'b0100);
    bus.write_request_i = '0;
    repeat (16) cyc();
    check("to_no_early_done", bus.write_done_o, 0);
    cyc();
    check("to_done", bus.write_done_o, 4'b0100);
    check("to_resp", bus.write_response_o, DECERR);
    bus.m_write_done_i = 1;
    bus.m_write_response_i = OKAY;
    bus.write_request_i = 4'b1001;
    wr_lat = 0;
    cyc();
    check("to_stray_ignored", bus.write_done_o, 0);
    check("to_resp_hold", bus.write_response_o, DECERR);
    check("to_ptr_adv", bus.write_grant_o, 4'b1000);
    bus.write_request_i = '0;
    cyc();
    cyc();
    check("to_next_done", bus.write_done_o, 4'b1000);
    do_reset();
    bus.write_request_i[1] = 1;
    wr_lat = 0;
    wr_resp_s = SLVERR;
    cyc();
    bus.write_request_i = '0;
    cyc();
    cyc();
    check("rs_first_done", bus.write_done_o, 4'b0010);
    bus.write_request_i[3] = 1;
    bus.write_address_i[3] = 32'h7100;
    wr_lat = -1;
    cyc();
    check("rs_grant", bus.write_grant_o, 4'b1000);
    bus.write_request_i = '0;
    cyc();
    check("rs_wait_addr", bus.m_write_address_o, 32'h7100);
    #2 ARESETN = 0;
    #1;
    check("rs_async_addr", bus.m_write_address_o, 0);
    check("rs_async_resp", bus.write_response_o, OKAY);
    check("rs_async_out", {bus.write_grant_o, bus.write_done_o, bus.m_write_start_o}, 0);
    repeat (3) begin
      cyc();
      check("rs_no_done", bus.write_done_o, 0);
    end
    ARESETN = 1;
    bus.write_request_i = 4'b1001;
    wr_lat = 0;
    wr_resp_s = OKAY;
    cyc();
    check("rs_restart_c0", bus.write_grant_o, 4'b0001);
    do_reset();
    for (int ch = 0; ch < 2; ch++) begin
      gc[ch] = -1;
      dc[ch] = -1;
      freec[ch] = 0;
      ptr[ch] = 0;
      lresp[ch] = OKAY;
    end
    ldata = '0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int ch = 0; ch < 2; ch++) if (cyc_n == dc[ch]) lresp[ch] = tresp[ch];
      if (cyc_n == dc[1]) ldata = tdata;
      check("rnd_wgrant", bus.write_grant_o, cyc_n == gc[0] ? 1 << own[0] : 0);
      check("rnd_rgrant", bus.read_grant_o, cyc_n == gc[1] ? 1 << own[1] : 0);
      check("rnd_wstart", bus.m_write_start_o, cyc_n == gc[0]);
      check("rnd_rstart", bus.m_read_start_o, cyc_n == gc[1]);
      check("rnd_wdone", bus.write_done_o, cyc_n == dc[0] ? 1 << own[0] : 0);
      check("rnd_rdone", bus.read_done_o, cyc_n == dc[1] ? 1 << own[1] : 0);
      check("rnd_wresp", bus.write_response_o, lresp[0]);
      check("rnd_rresp", bus.read_response_o, lresp[1]);
      check("rnd_rdata", bus.read_data_o, ldata);
      if (cyc_n == gc[0]) begin
        check("rnd_waddr", bus.m_write_address_o, eaddr[0]);
        check("rnd_wdata", bus.m_write_data_o, edata);
        check("rnd_wstrb", bus.m_write_strobe_o, estrb);
      end
      if (cyc_n == gc[1]) check("rnd_raddr", bus.m_read_address_o, eaddr[1]);
      for (int k = 0; k < N; k++) begin
        if (cyc_n == gc[0] && own[0] == k) bus.write_request_i[k] = 0;
        else if (!bus.write_request_i[k] && $urandom_range(0, 3) == 0) begin
          bus.write_request_i[k] = 1;
          bus.write_address_i[k] = $urandom;
          bus.write_data_i[k] = $urandom;
          bus.write_strobe_i[k] = 4'($urandom);
        end
        if (cyc_n == gc[1] && own[1] == k) bus.read_request_i[k] = 0;
        else if (!bus.read_request_i[k] && $urandom_range(0, 3) == 0) begin
          bus.read_request_i[k] = 1;
          bus.read_address_i[k] = $urandom;
        end
      end
      if (cyc_n >= freec[0] && |bus.write_request_i) begin
        w = rr_pick(bus.write_request_i, ptr[0]);
        lat = $urandom_range(0, 4);
        own[0] = w;
        gc[0] = cyc_n + 1;
        eaddr[0] = bus.write_address_i[w];
        edata = bus.write_data_i[w];
        estrb = bus.write_strobe_i[w];
        wr_resp_s = axi_response_t'(2'($urandom_range(0, 3)));
        wr_lat = lat == 4 ? -1 : lat;
        dc[0] = lat == 4 ? cyc_n + 18 : cyc_n + 3 + lat;
        tresp[0] = lat == 4 ? DECERR : wr_resp_s;
        freec[0] = dc[0];
        ptr[0] = (w + 1) % N;
      end
      if (cyc_n >= freec[1] && |bus.read_request_i) begin
        w = rr_pick(bus.read_request_i, ptr[1]);
        lat = $urandom_range(0, 4);
        own[1] = w;
        gc[1] = cyc_n + 1;
        eaddr[1] = bus.read_address_i[w];
        rd_resp_s = axi_response_t'(2'($urandom_range(0, 3)));
        rd_data_s = $urandom;
        rd_lat = lat == 4 ? -1 : lat;
        dc[1] = lat == 4 ? cyc_n + 18 : cyc_n + 3 + lat;
        tresp[1] = lat == 4 ? DECERR : rd_resp_s;
        tdata = lat == 4 ? 32'h0 : rd_data_s;
        freec[1] = dc[1];
        ptr[1] = (w + 1) % N;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
